// File: rtl/packet_writer.sv
// packet_writer: stores one incoming 32-bit packet stream into the packet RAM
// from word 0. It records the byte length, then holds the buffer until the
// consumer acknowledges it. Packets that overflow the buffer are dropped and
// counted.
module packet_writer #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    input  logic [1:0]              s_last_bytes,
    output logic                    ram_en,
    output logic                    ram_wr_en,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [31:0]             ram_di,
    output logic                    pkt_ready,
    output logic [ADDR_WIDTH+2:0]   pkt_len,
    input  logic                    pkt_ack,
    output logic [15:0]             drop_cnt
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 3;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [LEN_W-1:0]        pkt_len_q;
    logic [15:0]             drop_cnt_q;

    logic                    accept;
    logic [2:0]              last_bytes;
    logic [LEN_W-1:0]        last_len;

    // Stream handshake and RAM write port, decoded from registered state only
    always_comb begin
        s_ready   = (state != HOLD);
        ram_wr_en = (state == FILL) && s_valid;
        ram_en    = ram_wr_en;
        ram_addr  = wr_addr;
        ram_di    = s_data;
        pkt_ready = (state == HOLD);
        pkt_len   = pkt_len_q;
        drop_cnt  = drop_cnt_q;
    end

    // Byte length if the current beat closes the packet (0 encodes a full word)
    always_comb begin
        accept     = s_valid && s_ready;
        last_bytes = (s_last_bytes == 2'd0) ? 3'd4 : {1'b0, s_last_bytes};
        last_len   = LEN_W'({wr_addr, 2'b00}) + LEN_W'(last_bytes);
    end

    // Packet FSM with write pointer, length and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            wr_addr    <= '0;
            pkt_len_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        if (s_last) begin
                            pkt_len_q <= last_len;
                            state     <= HOLD;
                        end else if (wr_addr == LAST_ADDR) begin
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (accept && s_last) begin
                        wr_addr <= '0;
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                        state <= FILL;
                    end
                end
                HOLD: begin
                    if (pkt_ack) begin
                        wr_addr <= '0;
                        state   <= FILL;
                    end
                end
                default: begin
                    wr_addr <= '0;
                    state   <= FILL;
                end
            endcase
        end
    end

endmodule
